// File: rtl/seq_detect_fsm.sv
// Serial pattern detector: shifts in qualified bits, compares the last N
// against PATTERN, pulses x on a match, flags y once N bits of history are
// held, and keeps a saturating count of matches.
module seq_detect_fsm #(
    parameter int              N       = 4,
    parameter logic [N-1:0]    PATTERN = 4'b1011,
    parameter int              OVERLAP = 1,
    parameter int              CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i,
    input  logic             j,
    input  logic             clr,
    output logic             x,
    output logic             y,
    output logic [CNT_W-1:0] match_cnt,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        ARMED = 2'd2
    } state_t;

    localparam int               FILL_W  = $clog2(N + 1);
    localparam logic [FILL_W-1:0] FULL   = FILL_W'(N);
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

    state_t              state, state_n;
    logic [N-1:0]        hist, hist_n;
    logic [FILL_W-1:0]   fill, fill_n;
    logic [FILL_W-1:0]   fill_inc;
    logic [N-1:0]        hist_shift;
    logic                match;

    // Next-state, history and match evaluation for the current edge.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_n    = state;
        hist_n     = hist;
        fill_n     = fill;
        match      = 1'b0;
        hist_shift = {hist[N-2:0], i};
        fill_inc   = (fill == FULL) ? FULL : fill + 1'b1;

        case (state)
            IDLE, FILL, ARMED: begin
                if (j) begin
                    hist_n  = hist_shift;
                    fill_n  = fill_inc;
                    match   = (fill_inc == FULL) && (hist_shift == PATTERN);
                    state_n = (fill_inc == FULL) ? ARMED : FILL;
                    // Non-overlapping mode: demand N fresh bits after each hit.
                    if (match && (OVERLAP == 0)) begin
                        fill_n  = '0;
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                // Illegal encoding: drop history and restart cleanly.
                state_n = IDLE;
                fill_n  = '0;
            end
        endcase
    end

    // State, history, flags and match counter, with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rstn) begin
            state     <= IDLE;
            hist      <= '0;
            fill      <= '0;
            x         <= 1'b0;
            y         <= 1'b0;
            match_cnt <= '0;
        end else begin
            state <= state_n;
            hist  <= hist_n;
            fill  <= fill_n;
            x     <= match;
            y     <= (state_n == ARMED);
            if (clr)
                match_cnt <= '0;
            else if (match && (match_cnt != CNT_MAX))
                match_cnt <= match_cnt + 1'b1;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_seq_detect_fsm.sv
// Directed bench for seq_detect_fsm: three instances share stimulus
// (1011 overlapping, 1011 non-overlapping, 1111 overlapping).
module tb_seq_detect_fsm;

    logic       clk = 1'b0;
    logic       rstn, i, j, clr;

    logic       x_a, y_a, x_b, y_b, x_c, y_c;
    logic [3:0] cnt_a, cnt_b, cnt_c;
    logic [1:0] st_a, st_b, st_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_detect_fsm #(.N(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(4)) dut_a (
        .clk(clk), .rstn(rstn), .i(i), .j(j), .clr(clr),
        .x(x_a), .y(y_a), .match_cnt(cnt_a), .state_o(st_a));

    seq_detect_fsm #(.N(4), .PATTERN(4'b1011), .OVERLAP(0), .CNT_W(4)) dut_b (
        .clk(clk), .rstn(rstn), .i(i), .j(j), .clr(clr),
        .x(x_b), .y(y_b), .match_cnt(cnt_b), .state_o(st_b));

    seq_detect_fsm #(.N(4), .PATTERN(4'b1111), .OVERLAP(1), .CNT_W(4)) dut_c (
        .clk(clk), .rstn(rstn), .i(i), .j(j), .clr(clr),
        .x(x_c), .y(y_c), .match_cnt(cnt_c), .state_o(st_c));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply inputs, take one rising edge, then settle 1 ns before sampling.
    task automatic step(input logic bi, input logic bj);
        i = bi;
        j = bj;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        step(1'b0, 1'b0);
        rstn = 1'b1;
    endtask

    logic [6:0] stream;
    logic [1:0] exp_st_a [7];
    logic       exp_x_a  [7];
    logic [3:0] exp_c_a  [7];
    logic [1:0] exp_st_b [7];
    logic       exp_x_b  [7];
    logic [3:0] exp_c_b  [7];

    initial begin
        rstn = 1'b0; i = 1'b0; j = 1'b0; clr = 1'b0;
        #2;

        // ---------------- Reset state ----------------
        do_reset();
        check("rst_state", st_a, 2'd0);
        check("rst_x", x_a, 1'b0);
        check("rst_y", y_a, 1'b0);
        check("rst_cnt", cnt_a, 4'd0);

        // ------- Basic + overlap stream 1,0,1,1,0,1,1 (oldest first) -------
        stream   = 7'b1011011;
        exp_st_a = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2};
        exp_x_a  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        exp_c_a  = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2};
        exp_st_b = '{2'd1, 2'd1, 2'd1, 2'd0, 2'd1, 2'd1, 2'd1};
        exp_x_b  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        exp_c_b  = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1};
        for (int k = 0; k < 7; k++) begin
            step(stream[6-k], 1'b1);
            check($sformatf("ov1_state_e%0d", k+1), st_a, exp_st_a[k]);
            check($sformatf("ov1_x_e%0d", k+1), x_a, exp_x_a[k]);
            check($sformatf("ov1_y_e%0d", k+1), y_a, (exp_st_a[k] == 2'd2));
            check($sformatf("ov1_cnt_e%0d", k+1), cnt_a, exp_c_a[k]);
            check($sformatf("ov0_state_e%0d", k+1), st_b, exp_st_b[k]);
            check($sformatf("ov0_x_e%0d", k+1), x_b, exp_x_b[k]);
            check($sformatf("ov0_cnt_e%0d", k+1), cnt_b, exp_c_b[k]);
        end
        // Qualifier low: x drops, state holds.
        step(1'b1, 1'b0);
        check("j0_x_drop", x_a, 1'b0);
        check("j0_state_hold", st_a, 2'd2);
        check("j0_cnt_hold", cnt_a, 4'd2);

        // ---------------- Qualifier gaps ----------------
        do_reset();
        step(1'b1, 1'b1);
        check("gap_q1_state", st_a, 2'd1);
        step(1'($urandom_range(0, 1)), 1'b0);
        check("gap_a_state", st_a, 2'd1);
        check("gap_a_x", x_a, 1'b0);
        step(1'b0, 1'b1);
        check("gap_q2_state", st_a, 2'd1);
        step(1'($urandom_range(0, 1)), 1'b0);
        step(1'($urandom_range(0, 1)), 1'b0);
        check("gap_b_state", st_a, 2'd1);
        check("gap_b_x", x_a, 1'b0);
        step(1'b1, 1'b1);
        check("gap_q3_x", x_a, 1'b0);
        step(1'($urandom_range(0, 1)), 1'b0);
        check("gap_c_state", st_a, 2'd1);
        step(1'b1, 1'b1);
        check("gap_q4_state", st_a, 2'd2);
        check("gap_q4_x", x_a, 1'b1);
        check("gap_q4_cnt", cnt_a, 4'd1);
        step(1'($urandom_range(0, 1)), 1'b0);
        check("gap_after_x", x_a, 1'b0);
        check("gap_after_state", st_a, 2'd2);
        check("gap_after_cnt", cnt_a, 4'd1);

        // ---------------- Reset mid-operation ----------------
        do_reset();
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        rstn = 1'b0;
        step(1'b1, 1'b1);   // reset wins over a qualified bit
        rstn = 1'b1;
        check("midrst_state", st_a, 2'd0);
        check("midrst_x", x_a, 1'b0);
        step(1'b1, 1'b1);
        check("midrst_bit_state", st_a, 2'd1);
        check("midrst_bit_x", x_a, 1'b0);
        check("midrst_bit_cnt", cnt_a, 4'd0);
        // Three more bits complete 1011 only if fill restarted at 1.
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        check("midrst_pre_x", x_a, 1'b0);
        step(1'b1, 1'b1);
        check("midrst_match_x", x_a, 1'b1);
        check("midrst_match_cnt", cnt_a, 4'd1);

        // ---------------- Saturation and clear (PATTERN 1111) ----------------
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            step(1'b1, 1'b1);
            check($sformatf("sat_x_e%0d", k), x_c, (k >= 4));
            check($sformatf("sat_cnt_e%0d", k), cnt_c, (k < 4) ? 0 : ((k - 3 > 15) ? 15 : k - 3));
        end
        clr = 1'b1;
        step(1'b1, 1'b1);
        clr = 1'b0;
        check("clr_cnt", cnt_c, 4'd0);
        check("clr_x", x_c, 1'b1);
        check("clr_state", st_c, 2'd2);
        step(1'b1, 1'b1);
        check("post_clr_cnt", cnt_c, 4'd1);
        check("post_clr_x", x_c, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_detect_fsm.md
Name: seq_detect_fsm

Overview:
Parametrised serial pattern-detector FSM, the successor to the fixed two-input/two-output Moore FSMs in this chapter. It samples serial bit `i` when qualifier `j` is high and compares the last N qualified bits against a compile-time PATTERN. It pulses `x` on a match, flags `y` while enough history is held to match, and keeps a saturating match counter. It is driven by the chapter's implicit-port testbenches: top-level `.*` connection, `$monitor` of the state name.

Parameters:
- N, 4, pattern length in bits; legal range 2..32.
- PATTERN, 4'b1011, N-bit target. PATTERN[N-1] is the oldest bit received; PATTERN[0] is the newest.
- OVERLAP, 1, 1 = overlapping matches allowed; 0 = history restarts after each match.
- CNT_W, 4, width of match_cnt.

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  synchronous active-low reset, sampled on posedge clk.
- i  input  1  serial data bit.
- j  input  1  sample-valid qualifier; `i` is consumed only when j=1.
- clr  input  1  synchronous clear of match_cnt.
- x  output  1  match pulse, registered, one cycle wide per match.
- y  output  1  armed flag; high when state==ARMED.
- match_cnt  output  CNT_W  saturating count of matches since reset or clr.
- state_o  output  2  current state encoding (IDLE=0, FILL=1, ARMED=2).

Behaviour:
- Reset: at a posedge clk with rstn=0, the following registers clear: hist=0, fill=0, state=IDLE, x=0, y=0, match_cnt=0. The reset has priority over all inputs. Asserting rstn=0 mid-sequence discards all partial history.
- Internal registers:
  - hist: N-bit shift register, newest bit in LSB.
  - fill: count 0..N, saturating at N.
- When j=1 at a posedge:
  - hist_n = {hist[N-2:0], i}.
  - fill_n = min(fill+1, N).
  - match = (fill_n==N) && (hist_n==PATTERN).
- When j=0: hist, fill and state hold; x is driven 0 on the next edge; `i` is ignored.
- x is registered: x <= match. x is high for exactly the one cycle after the edge that sampled the final pattern bit (latency 1 clock). With back-to-back matches, x stays high on consecutive cycles.
- OVERLAP=1: on a match, hist and fill update normally, so a new match is possible on the very next qualified bit if the pattern permits.
- OVERLAP=0: on a match, fill <= 0 and state <= IDLE. hist may keep its value, but the next match requires N fresh qualified bits.
- State machine (Moore; state_o and y are registered):
  - IDLE: fill==0. On j=1 go to FILL, or to ARMED when fill_n==N (not reachable for N>=2).
  - FILL: 0<fill<N. On j=1, go to ARMED when fill_n==N, else stay in FILL.
  - ARMED: fill==N. Stay in ARMED. In OVERLAP=0, a match returns the FSM to IDLE.
  - y = (state==ARMED).
- match_cnt:
  - On a match, it increments by 1, saturating at 2^CNT_W-1 (no wrap).
  - clr=1 forces match_cnt to 0 on that edge. clr wins over a simultaneous match: cnt=0, but x still pulses.
  - clr has no effect on hist, fill or state.
- No combinational path exists from inputs to outputs.
- An unknown state encoding (3) recovers to IDLE on the next edge.

Test Plan (N=4, PATTERN=4'b1011, CNT_W=4 unless noted):
- Basic (OVERLAP=1): after reset, drive j=1 with i=1,0,1,1 on 4 edges.
  - state_o goes 1,1,1,2.
  - y rises after the 4th edge.
  - x=1 for exactly one cycle after the 4th edge; match_cnt=1.
- Overlap: drive stream 1,0,1,1,0,1,1.
  - With OVERLAP=1: x pulses after edges 4 and 7; match_cnt=2.
  - With OVERLAP=0, same stream: a single x pulse after edge 4; state_o returns to 0 then goes 1,1,1; match_cnt=1.
- Qualifier gaps: interleave j=0 cycles (with i toggled randomly) between the bits 1,0,1,1.
  - Exactly one x pulse, after the edge sampling the final qualified 1.
  - No state change on the j=0 cycles.
- Reset mid-operation: feed 1,0,1, drive rstn=0 for one edge, then feed 1.
  - No x pulse; state_o=1 and fill=1 after that bit.
  - match_cnt=0.
- Saturation and clear:
  - Drive 17 back-to-back matches (OVERLAP=1, PATTERN=4'b1111, continuous i=1). match_cnt stops at 15; x stays high every cycle after the 4th edge.
  - Then assert clr on the same edge as a match: match_cnt=0 and x=1.
